mac_requant: RTL and testbench



---
 rtl/mac_requant.sv | 140 ++++++++++++++
 tb/tb_mac_requant.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mac_requant.sv
// Accumulates signed 48-bit MAC beats per group, then bias + round + shift + ReLU + int8 saturate,
// with results queued in a small output FIFO under valid/ready backpressure.
module mac_requant #(
  parameter int OUT_DEPTH = 4,
  parameter int SAT_CNT_W = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [47:0]          IN_P,
  input  logic                 IN_VALID,
  input  logic                 IN_LAST,
  output logic                 IN_READY,
  input  logic [31:0]          BIAS,
  input  logic [5:0]           SHIFT,
  input  logic                 RELU_EN,
  output logic [7:0]           OUT_Q,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [SAT_CNT_W-1:0] SAT_CNT,
  input  logic                 CLR_STATS
);
  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = AW + 1;

  // accumulator and S1 stage
  logic [47:0] acc_q, acc_d, acc_sum;
  logic        first_q, first_d;
  logic        s1_vld_q, s1_vld_d;
  logic [47:0] s1_sum_q, s1_sum_d;
  logic [5:0]  s1_shift_q, s1_shift_d;
  logic        s1_relu_q, s1_relu_d;
  logic        in_acc;

  // S2 (combinational off S1) and FIFO
  logic        [48:0] sum49, rnd, rsum;
  logic signed [48:0] r, r_c;
  logic        [7:0]  q8;
  logic               sat_hit;

  logic [OUT_DEPTH-1:0][7:0] mem_q, mem_d;
  logic [AW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      wr_en, rd_en;
  logic [SAT_CNT_W-1:0]      sat_q, sat_d;

  // S1 occupancy is reserved against FIFO space so a result never stalls in the pipe
  assign IN_READY = (cnt_q + CW'(s1_vld_q)) < CW'(OUT_DEPTH);
  assign in_acc   = IN_VALID && IN_READY;
  assign acc_sum  = first_q ? IN_P : acc_q + IN_P;

  always_comb begin
    acc_d      = acc_q;
    first_d    = first_q;
    s1_vld_d   = 1'b0;
    s1_sum_d   = s1_sum_q;
    s1_shift_d = s1_shift_q;
    s1_relu_d  = s1_relu_q;
    if (in_acc) begin
      acc_d   = acc_sum;
      first_d = IN_LAST;
      if (IN_LAST) begin
        s1_vld_d   = 1'b1;
        s1_sum_d   = acc_sum + {{16{BIAS[31]}}, BIAS};
        s1_shift_d = (SHIFT > 6'd47) ? 6'd47 : SHIFT;
        s1_relu_d  = RELU_EN;
      end
    end
  end

  // 49-bit rounding path: adding the half-LSB can never overflow
  always_comb begin
    sum49   = {s1_sum_q[47], s1_sum_q};
    rnd     = (s1_shift_q != 6'd0) ? (49'd1 << (s1_shift_q - 6'd1)) : 49'd0;
    rsum    = sum49 + rnd;
    r       = $signed(rsum) >>> s1_shift_q;
    r_c     = (s1_relu_q && r[48]) ? 49'sd0 : r;
    sat_hit = 1'b0;
    q8      = r_c[7:0];
    if (r_c > 49'sd127) begin
      q8      = 8'h7f;
      sat_hit = 1'b1;
    end else if (r_c < -49'sd128) begin
      q8      = 8'h80;
      sat_hit = 1'b1;
    end
  end

  assign wr_en     = s1_vld_q;
  assign OUT_VALID = (cnt_q != '0);
  assign rd_en     = OUT_VALID && OUT_READY;
  assign OUT_Q     = OUT_VALID ? mem_q[rd_ptr_q] : 8'h00;
  assign SAT_CNT   = sat_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = q8;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    cnt_d = cnt_q + CW'(wr_en) - CW'(rd_en);
  end

  // clear has priority over a same-cycle saturation event
  always_comb begin
    sat_d = sat_q;
    if (CLR_STATS)                          sat_d = '0;
    else if (s1_vld_q && sat_hit && ~&sat_q) sat_d = sat_q + SAT_CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_q      <= '0;
      first_q    <= 1'b1;
      s1_vld_q   <= 1'b0;
      s1_sum_q   <= '0;
      s1_shift_q <= '0;
      s1_relu_q  <= 1'b0;
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      sat_q      <= '0;
    end else begin
      acc_q      <= acc_d;
      first_q    <= first_d;
      s1_vld_q   <= s1_vld_d;
      s1_sum_q   <= s1_sum_d;
      s1_shift_q <= s1_shift_d;
      s1_relu_q  <= s1_relu_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
    end
  end
endmodule

// File: tb/tb_mac_requant.sv
// Directed bench for mac_requant: rounding/saturation/ReLU vectors, backpressure, reset, stats.
module tb_mac_requant;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [47:0] in_p;
  logic        in_valid, in_last, in_ready;
  logic [31:0] bias;
  logic [5:0]  shift;
  logic        relu_en;
  logic [7:0]  out_q;
  logic        out_valid, out_ready;
  logic [1:0]  sat_cnt;
  logic        clr_stats;

  int n_cmp = 0;
  int n_bad = 0;
  int got[8];
  int n_got, k;
  logic rdy;

  always #5 clk = ~clk;

  mac_requant #(.OUT_DEPTH(4), .SAT_CNT_W(2)) dut (
    .CLK(clk), .RST_N(rst_n), .IN_P(in_p), .IN_VALID(in_valid), .IN_LAST(in_last),
    .IN_READY(in_ready), .BIAS(bias), .SHIFT(shift), .RELU_EN(relu_en),
    .OUT_Q(out_q), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .SAT_CNT(sat_cnt), .CLR_STATS(clr_stats)
  );

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d want %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic logic [47:0] q48();
    return 48'($signed(out_q));
  endfunction

  // offer one beat; entered and left #1 after a rising edge
  task automatic beat(input longint p, input bit last, input int b, input logic [5:0] sh, input bit relu);
    bit ok;
    ok       = 1'b0;
    in_p     = 48'(p);
    in_last  = last;
    bias     = 32'(b);
    shift    = sh;
    relu_en  = relu;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("beat_accept", 48'(ok), 48'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // result must be absent in the cycle after the last beat, present the cycle after that
  task automatic res(input string tag, input int exp_q, input int exp_sat);
    @(negedge clk);
    chk({tag, "_early"}, 48'(out_valid), 48'(0));
    @(negedge clk);
    chk({tag, "_vld"}, 48'(out_valid), 48'(1));
    chk({tag, "_q"}, q48(), 48'(exp_q));
    chk({tag, "_sat"}, 48'(sat_cnt), 48'(exp_sat));
    @(posedge clk); #1;
    pop();
  endtask

  initial begin
    rst_n = 1'b0; in_p = '0; in_valid = 1'b0; in_last = 1'b0; bias = '0;
    shift = '0; relu_en = 1'b0; out_ready = 1'b0; clr_stats = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_vld", 48'(out_valid), 48'(0));
    chk("rst_q", q48(), 48'(0));
    chk("rst_sat", 48'(sat_cnt), 48'(0));
    chk("rst_rdy", 48'(in_ready), 48'(1));
    @(posedge clk); #1;

    beat(40, 0, 0, 0, 0);  beat(-8, 1, 4, 1, 0);    res("basic", 18, 0);
    beat(100, 0, 0, 0, 0); beat(200, 0, 0, 0, 0);   beat(300, 1, 0, 2, 0);   res("sat_pos", 127, 1);
    beat(-100, 0, 0, 0, 0); beat(-200, 0, 0, 0, 0); beat(-300, 1, 0, 2, 0);  res("sat_neg", -128, 2);
    beat(-5, 1, 0, 1, 0);  res("rnd_neg", -2, 2);
    beat(5, 1, 0, 1, 0);   res("rnd_pos", 3, 2);
    beat(-50, 1, 0, 0, 1); res("relu", 0, 2);
    beat(-50, 1, 0, 0, 0); res("norelu", -50, 2);
    beat(10, 1, -20, 0, 0); res("bias_sext", -10, 2);
    beat(64'h4000_0000_0000, 1, 0, 6'd63, 0); res("shift_clamp", 1, 2);

    // backpressure: five one-beat groups against a stalled consumer
    k = 1; n_got = 0;
    in_p = 48'(1); in_last = 1'b1; bias = '0; shift = '0; relu_en = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 8) begin
        chk("bp_accepts", 48'(k - 1), 48'(4));
        chk("bp_rdy_low", 48'(in_ready), 48'(0));
        chk("bp_head", q48(), 48'(1));
        out_ready = 1'b1;
      end
      if (out_valid && out_ready && n_got < 8) begin
        got[n_got] = int'($signed(out_q));
        n_got++;
      end
      rdy = in_ready && in_valid;
      @(posedge clk); #1;
      if (rdy) begin
        k++;
        if (k > 5) in_valid = 1'b0;
        else       in_p = 48'(k);
      end
    end
    out_ready = 1'b0; in_last = 1'b0; in_valid = 1'b0;
    chk("bp_count", 48'(n_got), 48'(5));
    for (int i = 0; i < 5; i++) chk("bp_order", 48'(got[i]), 48'(i + 1));
    @(negedge clk);
    chk("bp_empty", 48'(out_valid), 48'(0));
    @(posedge clk); #1;

    // reset mid-group discards the partial sum
    beat(7, 0, 0, 0, 0); beat(9, 0, 0, 0, 0);
    rst_n = 1'b0;
    #3;
    chk("rst_mid_vld", 48'(out_valid), 48'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    beat(3, 1, 0, 0, 0); res("post_rst", 3, 0);

    // counter saturates at all-ones
    for (int i = 0; i < 4; i++) begin
      beat(1000, 1, 0, 0, 0);
      res("sat_stick", 127, (i < 3) ? i + 1 : 3);
    end
    clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    @(negedge clk);
    chk("clr_alone", 48'(sat_cnt), 48'(0));
    @(posedge clk); #1;
    beat(1000, 1, 0, 0, 0); res("sat_one", 127, 1);

    // clear coincident with a saturating result
    beat(1000, 1, 0, 0, 0);
    clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    @(negedge clk);
    chk("clr_wins", 48'(sat_cnt), 48'(0));
    chk("clr_q", q48(), 48'(127));
    @(posedge clk); #1;
    pop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
